tt_ksv_perceptron_inference: RTL and testbench

// - TinyTapeout user tile: single binary perceptron with 7 binary features, 7 signed 4-bit weights and a signed 4-bit bias.
// - Weights and bias are loaded through the uio_in bus. Inference is started from ui_in[7].
// - The class (0/1) is shown on a 7-segment display on uo_out[6:0]; uo_out[7] flags a valid result.

---
 rtl/ksv_perceptron_pkg.sv | 31 +++
 rtl/tt_ksv_perceptron_inference_seg7.sv | 33 +++
 rtl/tt_ksv_perceptron_inference.sv | 180 ++++++++++++++++++
 tb/tb_tt_ksv_perceptron_inference.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ksv_perceptron_pkg.sv
// ---------------------------------------------------------------------------
// ksv_perceptron_pkg
// Shared constants, FSM state type and helpers for the 7-input binary
// perceptron tile (tt_ksv_perceptron_inference) and its 7-segment decoder.
// ---------------------------------------------------------------------------
package ksv_perceptron_pkg;

    localparam int unsigned NUM_FEAT  = 7;   // binary features x0..x6
    localparam int unsigned W_W       = 4;   // signed weight / bias width
    localparam int unsigned ACC_W     = 8;   // signed accumulator width
    localparam int unsigned IDX_W     = 3;   // feature index / register address width
    localparam logic [2:0]  BIAS_ADDR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Segment patterns, bit0 = seg a .. bit6 = seg g, active-high
    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_ONE   = 7'h06;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Sign-extend a weight/bias to accumulator width
    function automatic logic [ACC_W-1:0] sext_w(input logic [W_W-1:0] v);
        return {{(ACC_W - W_W){v[W_W-1]}}, v};
    endfunction

endpackage

// File: rtl/tt_ksv_perceptron_inference_seg7.sv
// ---------------------------------------------------------------------------
// ksv_seg7_decoder
// Combinational display decoder for the perceptron result.
// Ports:
//   blank - show nothing (post-reset, before the first inference)
//   dash  - inference in progress
//   y     - class result (0/1), shown when neither blank nor dash
//   seg   - 7-segment pattern, bit0 = a .. bit6 = g, active-high
// Priority: blank > dash > y.
// ---------------------------------------------------------------------------
module ksv_seg7_decoder
    import ksv_perceptron_pkg::*;
(
    input  logic       blank,
    input  logic       dash,
    input  logic       y,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (dash) begin
            seg = SEG_DASH;
        end else if (y) begin
            seg = SEG_ONE;
        end else begin
            seg = SEG_ZERO;
        end
    end

endmodule

// File: rtl/tt_ksv_perceptron_inference.sv
// ---------------------------------------------------------------------------
// tt_ksv_perceptron_inference
// TinyTapeout tile: single binary perceptron, 7 binary features, 7 signed
// 4-bit weights plus a signed 4-bit bias. Weights/bias are written over
// uio_in, inference starts on a rising edge of ui_in[7], and the class is
// shown on a 7-segment display.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   ena     - tile enable (unused by the logic)
//   ui_in   - [6:0] feature vector x, [7] start request (rising edge)
//   uio_in  - [7] write enable, [6:4] address (0-6 = w0..w6, 7 = bias),
//             [3:0] signed value
//   uo_out  - [6:0] 7-segment pattern (a..g), [7] result valid
//   uio_out - constant 0
//   uio_oe  - constant 0 (all uio pins are inputs)
// ---------------------------------------------------------------------------
module tt_ksv_perceptron_inference
    import ksv_perceptron_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Register file: entries 0..6 are weights, entry BIAS_ADDR is the bias
    logic [W_W-1:0]   regs [0:NUM_FEAT];

    state_t           state;
    state_t           state_next;

    // x_lat[7] is tied low so the 3-bit index never selects past the vector
    logic [7:0]       x_lat;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [IDX_W-1:0] idx;
    logic             start_q;
    logic             start_edge;

    logic             valid_q;
    logic             disp_blank;
    logic             disp_dash;
    logic             y_q;
    logic [6:0]       seg;

    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [W_W-1:0]   wr_data;

    logic             do_write;
    logic             do_start;
    logic             do_step;
    logic             do_finish;

    logic             unused_ena;

    assign unused_ena = &{1'b0, ena};

    assign wr_en      = uio_in[7];
    assign wr_addr    = uio_in[6:4];
    assign wr_data    = uio_in[3:0];
    assign start_edge = ui_in[7] & ~start_q;

    assign acc_next = acc + (x_lat[idx] ? sext_w(regs[idx]) : '0);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and datapath controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_start   = 1'b0;
        do_step    = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE, DONE: begin
                do_write = wr_en;
                if (start_edge) begin
                    do_start   = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                do_step = 1'b1;
                if (idx == IDX_W'(NUM_FEAT - 1)) begin
                    do_finish  = 1'b1;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= NUM_FEAT; i++) begin
                regs[i] <= '0;
            end
        end else if (do_write) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Start edge detector (samples every cycle, regardless of state)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= ui_in[7];
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator datapath and result/display registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat      <= '0;
            acc        <= '0;
            idx        <= '0;
            valid_q    <= 1'b0;
            disp_blank <= 1'b1;
            disp_dash  <= 1'b0;
            y_q        <= 1'b0;
        end else begin
            if (do_start) begin
                x_lat      <= {1'b0, ui_in[6:0]};
                acc        <= sext_w(regs[BIAS_ADDR]);
                idx        <= '0;
                valid_q    <= 1'b0;
                disp_blank <= 1'b0;
                disp_dash  <= 1'b1;
            end else if (do_step) begin
                acc <= acc_next;
                idx <= idx + 1'b1;
                if (do_finish) begin
                    // Non-negative final sum (including zero) is class 1
                    y_q       <= ~acc_next[ACC_W-1];
                    valid_q   <= 1'b1;
                    disp_dash <= 1'b0;
                end
            end
        end
    end

    ksv_seg7_decoder u_seg7 (
        .blank (disp_blank),
        .dash  (disp_dash),
        .y     (y_q),
        .seg   (seg)
    );

    assign uo_out  = {valid_q, seg};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_ksv_perceptron_inference.sv
// ---------------------------------------------------------------------------
// tb_tt_ksv_perceptron_inference
// Self-checking bench for the perceptron tile: a table of weight/bias/feature
// vectors with hand-computed classes, plus directed sequences for held start,
// start/write during accumulation and reset in the middle of an inference.
// ---------------------------------------------------------------------------
module tb_tt_ksv_perceptron_inference;

    localparam logic [6:0] E_ZERO  = 7'h3F;
    localparam logic [6:0] E_ONE   = 7'h06;
    localparam logic [6:0] E_DASH  = 7'h40;

    typedef struct {
        string       name;
        logic [27:0] w;      // {w6, w5, ..., w0}
        logic [3:0]  bias;
        logic [6:0]  x;
        logic [6:0]  seg;    // expected display pattern
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned vectors;
    int unsigned miscompares;
    vec_t        vecs[$];

    tt_ksv_perceptron_inference dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [27:0] w, input logic [3:0] bias,
                           input logic [6:0] x, input logic [6:0] seg);
        vec_t v;
        v.name = name;
        v.w    = w;
        v.bias = bias;
        v.x    = x;
        v.seg  = seg;
        vecs.push_back(v);
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [3:0] val);
        uio_in = {1'b1, addr, val};
        tick();
        uio_in = 8'h00;
    endtask

    task automatic load(input logic [27:0] w, input logic [3:0] bias);
        for (int i = 0; i < 7; i++) begin
            write_reg(3'(i), w[i*4 +: 4]);
        end
        write_reg(3'd7, bias);
    endtask

    // Pulse start for one cycle and wait (bounded) for valid
    task automatic run_inference(input logic [6:0] x, input logic [6:0] exp_seg, input string tag);
        int n;
        ui_in = {1'b0, x};
        tick();
        ui_in = {1'b1, x};
        tick();
        n = 1;
        chk({tag, "_busy"}, uo_out, {1'b0, E_DASH});
        ui_in = {1'b0, x};
        while (!uo_out[7] && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_result"}, uo_out, {1'b1, exp_seg});
    endtask

    initial begin
        int n;
        int dash_cnt;
        int first_valid;

        vectors     = 0;
        miscompares = 0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;

        //                name          w6..w0                                   bias   x      seg
        add_vec("pos13",     {7{4'h3}},                                         4'h8, 7'h7F, E_ONE);
        add_vec("neg1",      {7{4'hF}},                                         4'h2, 7'h07, E_ZERO);
        add_vec("zero_sum",  {7{4'hF}},                                         4'h2, 7'h03, E_ONE);
        add_vec("min_m64",   {7{4'h8}},                                         4'h8, 7'h7F, E_ZERO);
        add_vec("max_56",    {7{4'h7}},                                         4'h7, 7'h7F, E_ONE);
        add_vec("mix_m12",   {4'h7, 4'hA, 4'h5, 4'hC, 4'h3, 4'hE, 4'h1},        4'h0, 7'h2A, E_ZERO);
        add_vec("mix_p16",   {4'h7, 4'hA, 4'h5, 4'hC, 4'h3, 4'hE, 4'h1},        4'h0, 7'h55, E_ONE);
        add_vec("x0_bm1",    {7{4'h7}},                                         4'hF, 7'h00, E_ZERO);
        add_vec("x0_b0",     {7{4'h8}},                                         4'h0, 7'h00, E_ONE);

        // Reset state
        repeat (5) tick();
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("post_rst_blank", uo_out, 8'h00);

        // Table-driven vectors
        foreach (vecs[i]) begin
            load(vecs[i].w, vecs[i].bias);
            run_inference(vecs[i].x, vecs[i].seg, vecs[i].name);
        end

        // Start held high for 20 cycles: exactly one inference
        load({7{4'h3}}, 4'h8);
        ui_in = 8'h7F;
        tick();
        ui_in = 8'hFF;
        dash_cnt    = 0;
        first_valid = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (uo_out[6:0] == E_DASH) dash_cnt++;
            if (uo_out[7] && first_valid == 0) first_valid = i;
        end
        chk("held_first_valid", first_valid, 8);
        chk("held_busy_cycles", dash_cnt, 7);
        chk("held_result", uo_out, {1'b1, E_ONE});
        ui_in = 8'h7F;
        tick();

        // Second start pulse and a weight write during ACC are both ignored
        load({7{4'h3}}, 4'h0);
        ui_in = 8'h7F;
        tick();
        ui_in = 8'hFF;
        tick();
        n = 1;
        ui_in = 8'h7F;
        tick();
        n++;
        ui_in  = 8'hFF;
        uio_in = {1'b1, 3'd0, 4'h8};
        tick();
        n++;
        ui_in  = 8'h7F;
        uio_in = 8'h00;
        while (!uo_out[7] && n < 20) begin
            tick();
            n++;
        end
        chk("restart_latency", n, 8);
        chk("restart_result", uo_out, {1'b1, E_ONE});
        run_inference(7'h01, E_ONE, "wr_acc_ignored");

        // Reset mid-ACC aborts; registers come back zeroed
        load({7{4'h3}}, 4'h7);
        ui_in = 8'h7F;
        tick();
        ui_in = 8'hFF;
        tick();
        ui_in = 8'h7F;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_uo_out", uo_out, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_still_blank", uo_out, 8'h00);
        write_reg(3'd2, 4'hD);
        run_inference(7'h7F, E_ZERO, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
